// File: rtl/sparc_npc_sel_ctrl.sv
// rtl/sparc_npc_sel_ctrl.sv - SPARC fetch-stage nPC source select and delayed-branch sequencer
module sparc_npc_sel_ctrl #(
    parameter int TRAP_FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       stall,
    input  logic       trap_req,
    input  logic       id_is_branch,
    input  logic       id_cond_true,
    input  logic       id_annul,
    input  logic       id_branch_always,
    input  logic       id_is_call,
    input  logic       id_is_jmpl,
    output logic [1:0] npc_sel,
    output logic       pc_ld,
    output logic       if_squash,
    output logic       trap_flush,
    output logic       in_delay_slot
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DELAY = 2'd1,
        ST_ANNUL = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_REL  = 2'b01;
    localparam logic [1:0] SEL_JMPL = 2'b10;
    localparam logic [1:0] SEL_TRAP = 2'b11;

    localparam logic [3:0] TRAP_CNT_LOAD = 4'(TRAP_FLUSH_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    logic [1:0] dec_sel;
    state_t     dec_next;
    logic       dec_squash;
    logic       br_taken;
    logic       br_annul;

    // Decode of the CTI currently in ID; only consulted in RUN and DELAY.
    always_comb begin
        dec_sel    = SEL_SEQ;
        dec_next   = ST_RUN;
        dec_squash = 1'b0;
        br_taken   = id_branch_always | id_cond_true;
        // The a-bit annuls the delay slot for BA and for any untaken branch.
        br_annul   = id_annul & (id_branch_always | ~id_cond_true);
        if (id_is_jmpl) begin
            dec_sel  = SEL_JMPL;
            dec_next = ST_DELAY;
        end else if (id_is_call) begin
            dec_sel  = SEL_REL;
            dec_next = ST_DELAY;
        end else if (id_is_branch) begin
            dec_sel    = br_taken ? SEL_REL : SEL_SEQ;
            dec_next   = br_annul ? ST_ANNUL : ST_DELAY;
            dec_squash = br_annul;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        npc_sel    = SEL_SEQ;
        pc_ld      = 1'b0;
        if_squash  = 1'b0;
        trap_flush = 1'b0;
        if (!reset_n) begin
            if_squash = 1'b1;
            state_d   = ST_RUN;
            cnt_d     = 4'd0;
        end else if (trap_req) begin
            npc_sel    = SEL_TRAP;
            pc_ld      = 1'b1;
            if_squash  = 1'b1;
            trap_flush = 1'b1;
            state_d    = ST_TRAP;
            cnt_d      = TRAP_CNT_LOAD;
        end else begin
            case (state_q)
                ST_TRAP: begin
                    trap_flush = 1'b1;
                    if (!stall) begin
                        pc_ld     = 1'b1;
                        if_squash = 1'b1;
                        if (cnt_q == 4'd0) begin
                            state_d = ST_RUN;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                ST_ANNUL: begin
                    if (!stall) begin
                        pc_ld   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // npc_sel follows decode even while stalled; commit waits for !stall.
                    npc_sel = dec_sel;
                    if (!stall) begin
                        pc_ld     = 1'b1;
                        if_squash = dec_squash;
                        state_d   = dec_next;
                    end
                end
            endcase
        end
    end

    assign in_delay_slot = reset_n & (state_q == ST_DELAY);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sparc_npc_sel_ctrl.sv
// tb/tb_sparc_npc_sel_ctrl.sv - directed-vector bench for sparc_npc_sel_ctrl
module tb_sparc_npc_sel_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       stall;
    logic       trap_req;
    logic       id_is_branch;
    logic       id_cond_true;
    logic       id_annul;
    logic       id_branch_always;
    logic       id_is_call;
    logic       id_is_jmpl;
    logic [1:0] npc_sel;
    logic       pc_ld;
    logic       if_squash;
    logic       trap_flush;
    logic       in_delay_slot;

    int checks = 0;
    int errors = 0;

    sparc_npc_sel_ctrl #(.TRAP_FLUSH_CYCLES(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .trap_req         (trap_req),
        .id_is_branch     (id_is_branch),
        .id_cond_true     (id_cond_true),
        .id_annul         (id_annul),
        .id_branch_always (id_branch_always),
        .id_is_call       (id_is_call),
        .id_is_jmpl       (id_is_jmpl),
        .npc_sel          (npc_sel),
        .pc_ld            (pc_ld),
        .if_squash        (if_squash),
        .trap_flush       (trap_flush),
        .in_delay_slot    (in_delay_slot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs packed as {rst_n, stall, trap, br, cond, annul, always, call, jmpl}.
    // Expected outputs as {sel[1:0], ld, squash, flush, dslot}.
    task automatic step(input string tag, input logic [8:0] in, input logic [5:0] exp);
        @(negedge clk);
        {reset_n, stall, trap_req, id_is_branch, id_cond_true, id_annul,
         id_branch_always, id_is_call, id_is_jmpl} = in;
        #2;
        check({tag, ".npc_sel"},  {2'b00, npc_sel},    {2'b00, exp[5:4]});
        check({tag, ".pc_ld"},    {3'b000, pc_ld},     {3'b000, exp[3]});
        check({tag, ".squash"},   {3'b000, if_squash}, {3'b000, exp[2]});
        check({tag, ".flush"},    {3'b000, trap_flush},{3'b000, exp[1]});
        check({tag, ".dslot"},    {3'b000, in_delay_slot}, {3'b000, exp[0]});
    endtask

    localparam logic [8:0] RST   = 9'b0_0000_0000;
    localparam logic [8:0] IDLE  = 9'b1_0000_0000;
    localparam logic [8:0] STL   = 9'b1_1000_0000;
    localparam logic [8:0] BE_T  = 9'b1_0011_0000;
    localparam logic [8:0] BNE_A = 9'b1_0010_1000;
    localparam logic [8:0] BN_0  = 9'b1_0010_0000;
    localparam logic [8:0] BA_A  = 9'b1_0010_1100;
    localparam logic [8:0] CALL  = 9'b1_0000_0010;
    localparam logic [8:0] JMPL  = 9'b1_0000_0001;
    localparam logic [8:0] TRAP  = 9'b1_0100_0000;
    localparam logic [8:0] STL_T = 9'b1_1011_0000;
    localparam logic [8:0] TRJS  = 9'b1_1100_0001;

    initial begin
        {reset_n, stall, trap_req, id_is_branch, id_cond_true, id_annul,
         id_branch_always, id_is_call, id_is_jmpl} = 9'b0;

        step("rst0", RST, 6'b00_0100);
        step("rst1", RST, 6'b00_0100);
        step("rst2", RST, 6'b00_0100);
        step("rel",  IDLE, 6'b00_1000);

        step("be_t",      BE_T, 6'b01_1000);
        step("be_t.ds",   IDLE, 6'b00_1001);
        step("be_t.run",  IDLE, 6'b00_1000);

        step("bne_a",     BNE_A, 6'b00_1100);
        step("annul.jmpl", JMPL, 6'b00_1000);
        step("run.jmpl",  JMPL, 6'b10_1000);
        step("jmpl.ds",   IDLE, 6'b00_1001);

        step("bn",        BN_0, 6'b00_1000);
        step("bn.ds",     IDLE, 6'b00_1001);

        step("ba_a",      BA_A, 6'b01_1100);
        step("ba_a.ann",  IDLE, 6'b00_1000);
        step("dcti.be",   BE_T, 6'b01_1000);
        step("dcti.call", CALL, 6'b01_1001);
        step("dcti.ds2",  IDLE, 6'b00_1001);
        step("dcti.run",  IDLE, 6'b00_1000);

        step("stl0",      STL_T, 6'b01_0000);
        step("stl1",      STL_T, 6'b01_0000);
        step("stl.go",    BE_T,  6'b01_1000);
        step("stl.ds",    STL,   6'b00_0001);
        step("stl.dsgo",  IDLE,  6'b00_1001);
        step("stl.run",   IDLE,  6'b00_1000);

        step("trap",      TRJS, 6'b11_1110);
        step("trap.c1",   IDLE, 6'b00_1110);
        step("trap.c2",   IDLE, 6'b00_1110);
        step("trap.run",  IDLE, 6'b00_1000);

        step("rtrap",     TRAP, 6'b11_1110);
        step("rtrap.re",  TRAP, 6'b11_1110);
        step("rtrap.c1",  IDLE, 6'b00_1110);
        step("rtrap.c2",  IDLE, 6'b00_1110);
        step("rtrap.run", IDLE, 6'b00_1000);

        step("trst",      TRAP, 6'b11_1110);
        step("trst.rst",  RST,  6'b00_0100);
        step("trst.run",  IDLE, 6'b00_1000);

        step("drst.be",   BE_T, 6'b01_1000);
        step("drst.rst",  RST,  6'b00_0100);
        step("drst.run",  IDLE, 6'b00_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
